// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the single-port memory arbiter:
//   arb_state_t : sequencer states (IDLE, REQ, RESP, DONE)
//   grant_t     : which requester owns the current access
//   LSU_*       : RV32I funct3 encodings for load/store size and sign
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane helper for the memory arbiter.
// Ports:
//   i_funct3    : access size/sign code
//   i_byteOff   : byte offset within the word (addr[1:0])
//   i_storeData : right-justified store data
//   i_loadWord  : raw word returned by memory
//   o_be        : store byte enables
//   o_laneData  : store data replicated onto the selected lanes
//   o_loadData  : extracted and sign/zero-extended load result
//   o_misalign  : access crosses its natural alignment
// ---------------------------------------------------------------------------
module lsu_align
    import mem_arb_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byteOff,
    input  logic [31:0] i_storeData,
    input  logic [31:0] i_loadWord,
    output logic [3:0]  o_be,
    output logic [31:0] o_laneData,
    output logic [31:0] o_loadData,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: replicate the low byte/half across the word so the memory
    // only has to honour the byte enables. Misaligned halves/words keep the
    // truncated lane choice and are merely flagged.
    always_comb begin
        o_be       = 4'b1111;
        o_laneData = i_storeData;
        o_misalign = 1'b0;
        case (i_funct3[1:0])
            2'b00: begin
                o_be       = 4'b0001 << i_byteOff;
                o_laneData = {4{i_storeData[7:0]}};
            end
            2'b01: begin
                o_be       = 4'b0011 << {i_byteOff[1], 1'b0};
                o_laneData = {2{i_storeData[15:0]}};
                o_misalign = i_byteOff[0];
            end
            default: begin
                o_be       = 4'b1111;
                o_laneData = i_storeData;
                o_misalign = |i_byteOff;
            end
        endcase
    end

    // Load side: pick the addressed byte or half, then extend it. Unknown
    // codes fall back to returning the whole word.
    always_comb begin
        w_byte = i_loadWord[7:0];
        case (i_byteOff)
            2'd1:    w_byte = i_loadWord[15:8];
            2'd2:    w_byte = i_loadWord[23:16];
            2'd3:    w_byte = i_loadWord[31:24];
            default: w_byte = i_loadWord[7:0];
        endcase
        w_half = i_byteOff[1] ? i_loadWord[31:16] : i_loadWord[15:0];
        case (i_funct3)
            LSU_B:   o_loadData = {{24{w_byte[7]}}, w_byte};
            LSU_H:   o_loadData = {{16{w_half[15]}}, w_half};
            LSU_BU:  o_loadData = {24'h0, w_byte};
            LSU_HU:  o_loadData = {16'h0, w_half};
            LSU_W:   o_loadData = i_loadWord;
            default: o_loadData = i_loadWord;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates one shared memory port between instruction fetch and the
// load/store path, steers store lanes and aligns/extends load data.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (forces a fetch grant
// after STARVE_LIMIT consecutive data grants while fetch is waiting).
// Ports:
//   clk, reset             : clock, async active-high reset
//   if_req/if_addr         : fetch request and address
//   if_rdata/if_valid      : fetched word and completion pulse
//   dm_req/dm_we/dm_funct3 : data request, store flag, size/sign code
//   dm_addr/dm_wdata       : data byte address and store data
//   dm_rdata               : aligned load result
//   mem_read_data_valid    : load completion pulse
//   mem_write_ready        : store completion pulse
//   misalign               : misaligned data access flag (with completion)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : memory request side
//   mem_ack/mem_rvalid/mem_rdata             : memory response side
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [2:0]  dm_funct3,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        mem_read_data_valid,
    output logic        mem_write_ready,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    arb_state_t  r_state;
    arb_state_t  w_nextState;
    grant_t      r_gnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_misalign;
    logic [31:0] r_ifRdata;
    logic [31:0] r_dmRdata;

    logic        w_anyReq;
    logic        w_takeDm;
    logic        w_fetchFirst;
    logic [2:0]  w_alFunct3;
    logic [1:0]  w_alOff;
    logic [3:0]  w_alBe;
    logic [31:0] w_alWdata;
    logic [31:0] w_alRdata;
    logic        w_alMisalign;

    assign w_anyReq = dm_req | if_req;
    assign w_takeDm = dm_req & ~w_fetchFirst;

    // One aligner serves both directions: in IDLE it shapes the incoming
    // store, afterwards it decodes the load using the captured access.
    assign w_alFunct3 = (r_state == IDLE) ? dm_funct3    : r_funct3;
    assign w_alOff    = (r_state == IDLE) ? dm_addr[1:0] : r_addr[1:0];

    lsu_align u_align (
        .i_funct3    (w_alFunct3),
        .i_byteOff   (w_alOff),
        .i_storeData (dm_wdata),
        .i_loadWord  (mem_rdata),
        .o_be        (w_alBe),
        .o_laneData  (w_alWdata),
        .o_loadData  (w_alRdata),
        .o_misalign  (w_alMisalign)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starveCnt;

    // Counts data grants won while fetch was waiting; any fetch grant, or a
    // data grant with fetch idle, starts the count over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starveCnt <= '0;
        end else if (r_state == IDLE && w_anyReq) begin
            if (!w_takeDm) begin
                r_starveCnt <= '0;
            end else if (if_req) begin
                r_starveCnt <= r_starveCnt + 1'b1;
            end else begin
                r_starveCnt <= '0;
            end
        end
    end

    assign w_fetchFirst = if_req && (r_starveCnt == CNT_MAX);
`else
    logic w_unusedStarveLimit;

    assign w_fetchFirst        = 1'b0;
    assign w_unusedStarveLimit = ^STARVE_LIMIT;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and the per-state strobes. DONE never looks at requests so
    // a requester still holding its req cannot be re-granted back to back.
    always_comb begin
        w_nextState         = r_state;
        mem_req             = 1'b0;
        if_valid            = 1'b0;
        mem_read_data_valid = 1'b0;
        mem_write_ready     = 1'b0;
        misalign            = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_nextState = r_we ? DONE : RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
                misalign    = r_misalign;
                if (r_gnt == GNT_IF) begin
                    if_valid = 1'b1;
                end else if (r_we) begin
                    mem_write_ready = 1'b1;
                end else begin
                    mem_read_data_valid = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Access capture in IDLE and load-result capture in RESP. Fetches are
    // plain word reads, so their byte enables and write data stay zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt      <= GNT_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_funct3   <= LSU_B;
            r_misalign <= 1'b0;
            r_ifRdata  <= '0;
            r_dmRdata  <= '0;
        end else begin
            if (r_state == IDLE && w_anyReq) begin
                if (w_takeDm) begin
                    r_gnt      <= GNT_DM;
                    r_we       <= dm_we;
                    r_addr     <= dm_addr;
                    r_funct3   <= dm_funct3;
                    r_be       <= dm_we ? w_alBe : 4'b0000;
                    r_wdata    <= dm_we ? w_alWdata : 32'h0;
                    r_misalign <= w_alMisalign;
                end else begin
                    r_gnt      <= GNT_IF;
                    r_we       <= 1'b0;
                    r_addr     <= if_addr;
                    r_funct3   <= LSU_W;
                    r_be       <= 4'b0000;
                    r_wdata    <= 32'h0;
                    r_misalign <= 1'b0;
                end
            end
            if (r_state == RESP && mem_rvalid) begin
                if (r_gnt == GNT_IF) begin
                    r_ifRdata <= mem_rdata;
                end else begin
                    r_dmRdata <= w_alRdata;
                end
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_ifRdata;
    assign dm_rdata  = r_dmRdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Stimulus pushes the expected memory
// request and expected completion into queues; a memory model and a
// completion monitor pop and compare them independently.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] data;
        logic        mis;
        int          cyc;
    } cmp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    localparam logic [2:0] K_IF = 3'b100;
    localparam logic [2:0] K_RD = 3'b010;
    localparam logic [2:0] K_WR = 3'b001;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_funct3;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        mem_read_data_valid;
    logic        mem_write_ready;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .if_req              (if_req),
        .if_addr             (if_addr),
        .if_rdata            (if_rdata),
        .if_valid            (if_valid),
        .dm_req              (dm_req),
        .dm_we               (dm_we),
        .dm_funct3           (dm_funct3),
        .dm_addr             (dm_addr),
        .dm_wdata            (dm_wdata),
        .dm_rdata            (dm_rdata),
        .mem_read_data_valid (mem_read_data_valid),
        .mem_write_ready     (mem_write_ready),
        .misalign            (misalign),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_be              (mem_be),
        .mem_ack             (mem_ack),
        .mem_rvalid          (mem_rvalid),
        .mem_rdata           (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;
    int doneCount  = 0;
    int ackWait    = 0;
    int rvWait     = 0;
    logic [31:0] memWord = 32'h80FF7F01;

    cmp_t  cmpQ[$];
    mreq_t memQ[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ifValid"},  64'(if_valid),            64'h0);
        checkOutput({tag, "_ifRdata"},  64'(if_rdata),            64'h0);
        checkOutput({tag, "_dmRdata"},  64'(dm_rdata),            64'h0);
        checkOutput({tag, "_rdValid"},  64'(mem_read_data_valid), 64'h0);
        checkOutput({tag, "_wrReady"},  64'(mem_write_ready),     64'h0);
        checkOutput({tag, "_misalign"}, 64'(misalign),            64'h0);
        checkOutput({tag, "_memReq"},   64'(mem_req),             64'h0);
        checkOutput({tag, "_memWe"},    64'(mem_we),              64'h0);
        checkOutput({tag, "_memAddr"},  64'(mem_addr),            64'h0);
        checkOutput({tag, "_memBe"},    64'(mem_be),              64'h0);
        checkOutput({tag, "_memWdata"}, 64'(mem_wdata),           64'h0);
    endtask

    // Waits (bounded) until n more completion pulses have been seen.
    task automatic waitDone(input int n, input int budget);
        int target;
        target = doneCount + n;
        for (int i = 0; i < budget && doneCount < target; i++) begin
            @(posedge clk);
            #1;
        end
        if (doneCount < target) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL completionTimeout: got %0d completions, expected %0d",
                     n - (target - doneCount), n);
        end
    endtask

    // Issues one data access with hand-computed expectations and holds the
    // request until its completion pulse.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expAddr, input logic [3:0] expBe,
                                 input logic [31:0] expWdata, input logic [31:0] expRdata,
                                 input logic expMis, input int ackW, input int rvW,
                                 input int lat);
        ackWait = ackW;
        rvWait  = rvW;
        memQ.push_back('{we, expAddr, expBe, expWdata});
        cmpQ.push_back('{(we ? K_WR : K_RD), expRdata, expMis, cyc + lat});
        dm_we     = we;
        dm_funct3 = f3;
        dm_addr   = addr;
        dm_wdata  = wdata;
        dm_req    = 1'b1;
        waitDone(1, 40);
        dm_req = 1'b0;
    endtask

    // Memory model: acks after ackWait cycles, returns memWord rvWait cycles
    // after the ack, and checks the request fields at the ack.
    initial begin : memModel
        logic  isRead;
        mreq_t e;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1) begin
                repeat (ackWait) begin
                    @(posedge clk);
                    #1;
                end
                mem_ack = 1'b1;
                isRead  = !mem_we;
                if (memQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL memRequest: got request at 0x%h, expected none", mem_addr);
                end else begin
                    e = memQ.pop_front();
                    checkOutput("memWe",    64'(mem_we),    64'(e.we));
                    checkOutput("memAddr",  64'(mem_addr),  64'(e.addr));
                    checkOutput("memBe",    64'(mem_be),    64'(e.be));
                    checkOutput("memWdata", 64'(mem_wdata), 64'(e.wdata));
                end
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
                if (isRead) begin
                    repeat (rvWait) begin
                        @(posedge clk);
                        #1;
                    end
                    mem_rvalid = 1'b1;
                    mem_rdata  = memWord;
                    @(posedge clk);
                    #1;
                    mem_rvalid = 1'b0;
                end
            end
        end
    end

    // Completion monitor: every pulse must match the next expected entry.
    initial begin : monitor
        cmp_t       e;
        logic [2:0] pulses;
        forever begin
            @(negedge clk);
            pulses = {if_valid, mem_read_data_valid, mem_write_ready};
            if (pulses != 3'b000) begin
                doneCount++;
                if (cmpQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedPulse: got pulses %b, expected none", pulses);
                end else begin
                    e = cmpQ.pop_front();
                    checkOutput("pulseKind", 64'(pulses), 64'(e.kind));
                    if (e.kind == K_RD) checkOutput("dmRdata", 64'(dm_rdata), 64'(e.data));
                    if (e.kind == K_IF) checkOutput("ifRdata", 64'(if_rdata), 64'(e.data));
                    checkOutput("misalign", 64'(misalign), 64'(e.mis));
                    if (e.cyc >= 0) checkOutput("completionCycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (misalign) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL strayMisalign: got 1, expected 0");
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_funct3 = 3'b000;
        dm_addr   = 32'h0;
        dm_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Stores: SB high lane, SH, misaligned SH with an ack wait, SW.
        applyStimulus(1'b1, 3'b000, 32'h00001003, 32'h000000A5, 32'h00001000, 4'b1000,
                      32'hA5A5A5A5, 32'h0, 1'b0, 0, 0, 2);
        applyStimulus(1'b1, 3'b001, 32'h00001002, 32'h1234BEEF, 32'h00001000, 4'b1100,
                      32'hBEEFBEEF, 32'h0, 1'b0, 0, 0, 2);
        applyStimulus(1'b1, 3'b001, 32'h00001001, 32'h0000BEEF, 32'h00001000, 4'b0011,
                      32'hBEEFBEEF, 32'h0, 1'b1, 1, 0, 3);
        applyStimulus(1'b1, 3'b010, 32'h00001004, 32'hDEADBEEF, 32'h00001004, 4'b1111,
                      32'hDEADBEEF, 32'h0, 1'b0, 0, 0, 2);

        // Loads against memory word 0x80FF7F01.
        applyStimulus(1'b0, 3'b000, 32'h00006002, 32'hFFFFFFFF, 32'h00006000, 4'b0000,
                      32'h0, 32'hFFFFFFFF, 1'b0, 0, 0, 3);
        applyStimulus(1'b0, 3'b100, 32'h00006002, 32'hFFFFFFFF, 32'h00006000, 4'b0000,
                      32'h0, 32'h000000FF, 1'b0, 0, 0, 3);
        applyStimulus(1'b0, 3'b000, 32'h00006003, 32'hFFFFFFFF, 32'h00006000, 4'b0000,
                      32'h0, 32'hFFFFFF80, 1'b0, 0, 0, 3);
        applyStimulus(1'b0, 3'b000, 32'h00006000, 32'hFFFFFFFF, 32'h00006000, 4'b0000,
                      32'h0, 32'h00000001, 1'b0, 0, 0, 3);
        applyStimulus(1'b0, 3'b100, 32'h00006001, 32'hFFFFFFFF, 32'h00006000, 4'b0000,
                      32'h0, 32'h0000007F, 1'b0, 0, 0, 3);
        applyStimulus(1'b0, 3'b001, 32'h00006002, 32'hFFFFFFFF, 32'h00006000, 4'b0000,
                      32'h0, 32'hFFFF80FF, 1'b0, 0, 0, 3);
        applyStimulus(1'b0, 3'b101, 32'h00006000, 32'hFFFFFFFF, 32'h00006000, 4'b0000,
                      32'h0, 32'h00007F01, 1'b0, 0, 0, 3);

        // Misaligned LW with 3 ack waits and 2 rvalid waits.
        applyStimulus(1'b0, 3'b010, 32'h00002002, 32'hFFFFFFFF, 32'h00002000, 4'b0000,
                      32'h0, 32'h80FF7F01, 1'b1, 3, 2, 8);

        // Simultaneous requests: data first, fetch at the next IDLE.
        ackWait = 0;
        rvWait  = 0;
        memQ.push_back('{1'b1, 32'h00003000, 4'b1111, 32'h11223344});
        memQ.push_back('{1'b0, 32'h00004000, 4'b0000, 32'h0});
        cmpQ.push_back('{K_WR, 32'h0, 1'b0, cyc + 2});
        cmpQ.push_back('{K_IF, 32'h80FF7F01, 1'b0, cyc + 6});
        dm_we     = 1'b1;
        dm_funct3 = 3'b010;
        dm_addr   = 32'h00003000;
        dm_wdata  = 32'h11223344;
        if_addr   = 32'h00004003;
        dm_req    = 1'b1;
        if_req    = 1'b1;
        waitDone(1, 40);
        dm_req = 1'b0;
        waitDone(1, 40);
        if_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Continuous contention from both requesters.
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (i == 4) begin
                memQ.push_back('{1'b0, 32'h00004000, 4'b0000, 32'h0});
                cmpQ.push_back('{K_IF, 32'h80FF7F01, 1'b0, -1});
            end else begin
                memQ.push_back('{1'b1, 32'h00003000, 4'b1111, 32'h11223344});
                cmpQ.push_back('{K_WR, 32'h0, 1'b0, -1});
            end
`else
            memQ.push_back('{1'b1, 32'h00003000, 4'b1111, 32'h11223344});
            cmpQ.push_back('{K_WR, 32'h0, 1'b0, -1});
`endif
        end
        dm_req = 1'b1;
        if_req = 1'b1;
        waitDone(6, 80);
        dm_req = 1'b0;
        if_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Reset while waiting for read data; rvalid then arrives in IDLE.
        ackWait = 0;
        rvWait  = 4;
        memQ.push_back('{1'b0, 32'h00005000, 4'b0000, 32'h0});
        dm_we     = 1'b0;
        dm_funct3 = 3'b000;
        dm_addr   = 32'h00005000;
        dm_req    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        dm_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("postReset");
        @(posedge clk);
        #1;

        // A store right after recovery must see IDLE timing.
        applyStimulus(1'b1, 3'b010, 32'h00007000, 32'h01020304, 32'h00007000, 4'b1111,
                      32'h01020304, 32'h0, 1'b0, 0, 0, 2);
        repeat (4) @(posedge clk);
        #1;

        checkOutput("pendingCompletions", 64'(cmpQ.size()), 64'h0);
        checkOutput("pendingMemRequests", 64'(memQ.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and load/store sequencer between the fetch stage, the load/store path and one shared memory port. Grants one access at a time, steers byte lanes for stores, and aligns and sign-extends load data. Produces the `mem_read_data_valid` / `mem_write_ready` pulses that decode uses to release load/store stalls.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch waits. Only used with the guard compiled in.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `if_req` in 1: fetch request; held until `if_valid`.
- `if_addr` in 32: fetch address; bits [1:0] ignored.
- `if_rdata` out 32: fetched word; valid with `if_valid`.
- `if_valid` out 1: one-cycle pulse.
- `dm_req` in 1: data request; held stable until its completion pulse.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_funct3` in 3: access size/sign (RV32I encoding).
- `dm_addr` in 32: byte address.
- `dm_wdata` in 32: store data, right-justified.
- `dm_rdata` out 32: aligned, extended load result.
- `mem_read_data_valid` out 1: one-cycle pulse with `dm_rdata`.
- `mem_write_ready` out 1: one-cycle pulse when the store is accepted.
- `misalign` out 1: one-cycle pulse, coincident with the completion pulse of a misaligned data access.
- `mem_req` out 1: memory request; held until `mem_ack`.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: word address, `{addr[31:2], 2'b00}`.
- `mem_wdata` out 32: lane-steered store data.
- `mem_be` out 4: byte enables; `4'b0000` on reads.
- `mem_ack` in 1: request accepted in this cycle.
- `mem_rvalid` in 1: read data present.
- `mem_rdata` in 32: read word.

## Operation
- **FSM states:** IDLE, REQ, RESP, DONE. Reset state is IDLE.
- **IDLE:** samples requests and registers the grant, address, byte enables and write data, then moves to REQ. Stays in IDLE if there is no request.
- **Priority:** `dm_req` beats `if_req`, except as modified by the starvation guard (see Configuration).
- **REQ:** `mem_req` is 1; `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are stable. On `mem_ack`: a write goes to DONE; a read goes to RESP.
- **RESP:** waits for `mem_rvalid`. When it arrives, captures the aligned result into the output register and moves to DONE. `mem_rvalid` is ignored in every state other than RESP.
- **DONE:** emits exactly one pulse of the matching output: `if_valid`, `mem_read_data_valid` or `mem_write_ready`. Requests are not sampled. Always returns to IDLE. This prevents a still-high `req` from being re-granted.
- **Store lanes** (by `dm_funct3[1:0]`):
  - `00` (SB): `be = 4'b0001 << addr[1:0]`; data is the low byte replicated ×4.
  - `01` (SH): `be = 4'b0011 << {addr[1], 1'b0}`; data is the low half replicated ×2.
  - `10` / `11` (SW): `be = 4'b1111`; data unchanged.
- **Load extraction:** select the byte at `addr[1:0]` or the half at `addr[1]`.
  - `000` LB and `001` LH: sign-extend.
  - `100` LBU and `101` LHU: zero-extend.
  - `010` and any other code: full word.
- **Misaligned accesses** (half with `addr[0]=1`, word with `addr[1:0]≠0`): the access is still performed using the truncated lane selection above; `misalign` pulses alongside the completion pulse.
- **Fetch:** always a full-word read with `mem_be=0`; `if_rdata` is the raw `mem_rdata`.

## Timing
- **Reset values:** every output is 0 and the state is IDLE; this holds while `reset` is high. Reset mid-transaction abandons the transaction. A late `mem_rvalid` arriving in IDLE is dropped.
- **Store latency:** request sampled in cycle N → `mem_req` high from N+1. With `mem_ack` in N+1, `mem_write_ready` pulses in N+2 and the FSM is back in IDLE in N+3.
- **Load latency:** `mem_ack` in N+1 and `mem_rvalid` in N+2 → `mem_read_data_valid` in N+3. Each extra wait cycle on `mem_ack` or `mem_rvalid` adds one cycle.
- **Issue rate:** at most one outstanding access; peak issue is one grant every 3 cycles for stores and every 4 for loads.
- **Simultaneous requests in IDLE:** one grant only. The loser's `req` remains pending and is re-evaluated at the next IDLE.
- **`mem_ack` and `mem_rvalid` in the same cycle:** `mem_rvalid` is not captured; it must arrive no earlier than the cycle after `mem_ack`.

## Configuration
- **`MEM_ARB_STARVE_GUARD_EN` defined:**
  - A counter (width `$clog2(STARVE_LIMIT+1)`) increments on each data grant made while `if_req` is high.
  - When the counter equals `STARVE_LIMIT` and `if_req` is high, fetch wins the next grant.
  - The counter clears on any fetch grant, and when a data grant is made with `if_req` low.
  - Reset value is 0.
- **Undefined:** strict data priority; no counter logic; `STARVE_LIMIT` unused.

## Structure
- **Package `mem_arb_pkg`:**
  - state enum `arb_state_t` {IDLE, REQ, RESP, DONE};
  - funct3 constants `LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`;
  - grant enum {GNT_IF, GNT_DM}.
- **Sub-module `lsu_align`:** purely combinational; performs store lane steering and `be` generation, load extraction/extension, and misalign detection. It is instantiated once in `mem_arbiter`.

## Test plan
- **SB:** `dm_addr=0x1003`, `dm_wdata=0x000000A5`, `funct3=000`, `mem_ack` same cycle as `mem_req` → `mem_be=4'b1000`, `mem_wdata=0xA5A5A5A5`, `mem_addr=0x1000`; `mem_write_ready` pulses 2 cycles after the request is sampled.
- **LB / LBU:** `mem_rdata=0x80FF7F01`, `addr[1:0]=2` → LB gives `dm_rdata=0xFFFFFFFF`; LBU gives `0x000000FF`. With `addr[1:0]=3`, LB gives `0xFFFFFF80`.
- **Simultaneous requests:** `if_req` and `dm_req` high together in IDLE → data granted first. Fetch is granted at the next IDLE, and `if_valid` pulses exactly once.
- **Starvation guard** (macro on, `STARVE_LIMIT=4`): continuous `dm_req` and `if_req` → grant order D,D,D,D,F,D… With the macro off, fetch is never granted.
- **Reset mid-load:** assert `reset` in RESP, then deliver `mem_rvalid` after release → no `mem_read_data_valid` pulse, all outputs 0, FSM in IDLE.
- **Misaligned LW and wait states:** LW at `0x2002` with 3 wait cycles on `mem_ack` and 2 on `mem_rvalid` → `mem_addr=0x2000`, `misalign` coincident with `mem_read_data_valid`, total latency 8 cycles.
